// File: rtl/oldland_exc_sequencer.sv
// Exception/interrupt entry sequencer for the oldland core: latches sources, drains
// the pipeline for IRQs, pulses entry strobes and redirects to the vector table.
// Optional NMI input is enabled by defining OLDLAND_EXC_NMI_EN.
module oldland_exc_sequencer #(
  parameter int unsigned DRAIN_MIN   = 2,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [25:0] vector_base,
  input  logic        irqs_enabled,
  input  logic        irq_req,
  input  logic        illegal_instr,
  input  logic        ifetch_abort,
  input  logic        data_abort,
  input  logic        pipeline_idle,
  input  logic [31:0] resume_pc,
`ifdef OLDLAND_EXC_NMI_EN
  input  logic        nmi_req,
`endif
  output logic        stall_fetch,
  output logic        flush,
  output logic        exception_start,
  output logic        irq_start,
  output logic        exception_disable_irqs,
  output logic [31:0] irq_fault_address,
  output logic        branch_req,
  output logic [31:0] branch_target,
  output logic        busy
);

  localparam int unsigned CntMax = (DRAIN_MIN > HOLD_CYCLES) ? DRAIN_MIN : HOLD_CYCLES;
  localparam int unsigned CntW   = (CntMax < 1) ? 1 : $clog2(CntMax + 1);
  localparam logic [CntW-1:0] DrainLoad = CntW'(DRAIN_MIN);
  localparam logic [CntW-1:0] HoldLoad  = CntW'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StEnter,
    StHold
  } state_e;

  typedef enum logic [2:0] {
    CauseIllegal,
    CauseIfetch,
    CauseData,
    CauseIrq
`ifdef OLDLAND_EXC_NMI_EN
    , CauseNmi
`endif
  } cause_e;

  state_e          state_q, state_d;
  cause_e          cause_q, cause_d;
  cause_e          sync_cause;
  cause_e          async_cause;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Sticky sync pending bits: [0] illegal, [1] ifetch abort, [2] data abort.
  logic [2:0]      pend_q, pend_d;
  logic [2:0]      pend_clr;
  logic [31:0]     fault_q, fault_d;
  logic            irq_qual;
  logic            async_req;
  logic            cause_is_sync;
  logic            in_enter;
  logic [5:0]      vec_off;

  assign irq_qual = irq_req & irqs_enabled;

`ifdef OLDLAND_EXC_NMI_EN
  logic nmi_prev_q;
  logic nmi_pend_q, nmi_pend_d;
  logic nmi_clr;

  // NMI is edge-triggered and sticky, so a held-high nmi_req fires only once.
  always_comb begin
    nmi_clr    = (state_q == StEnter) && (cause_q == CauseNmi);
    nmi_pend_d = (nmi_pend_q & ~nmi_clr) | (nmi_req & ~nmi_prev_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_prev_q <= 1'b0;
      nmi_pend_q <= 1'b0;
    end else begin
      nmi_prev_q <= nmi_req;
      nmi_pend_q <= nmi_pend_d;
    end
  end

  assign async_req   = irq_qual | nmi_pend_q;
  assign async_cause = nmi_pend_q ? CauseNmi : CauseIrq;
`else
  assign async_req   = irq_qual;
  assign async_cause = CauseIrq;
`endif

  always_comb begin
    if (pend_q[2]) begin
      sync_cause = CauseData;
    end else if (pend_q[1]) begin
      sync_cause = CauseIfetch;
    end else begin
      sync_cause = CauseIllegal;
    end
  end

  assign cause_is_sync = (cause_q == CauseIllegal) || (cause_q == CauseIfetch) ||
                         (cause_q == CauseData);
  assign in_enter      = (state_q == StEnter);

  always_comb begin
    pend_clr = 3'b000;
    if (in_enter) begin
      case (cause_q)
        CauseIllegal: pend_clr = 3'b001;
        CauseIfetch:  pend_clr = 3'b010;
        CauseData:    pend_clr = 3'b100;
        default:      pend_clr = 3'b000;
      endcase
    end
    // A source re-asserting in the cycle it is serviced is a new event and stays pending.
    pend_d = (pend_q & ~pend_clr) | {data_abort, ifetch_abort, illegal_instr};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    fault_d = fault_q;
    flush   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|pend_q) begin
          state_d = StEnter;
          cause_d = sync_cause;
          flush   = 1'b1;
        end else if (async_req) begin
          state_d = StDrain;
          cnt_d   = DrainLoad;
        end
      end

      StDrain: begin
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - CntW'(1);
        if (|pend_q) begin
          // Sync fault wins; the IRQ is simply re-sampled after the handler entry.
          state_d = StEnter;
          cause_d = sync_cause;
          flush   = 1'b1;
        end else if (!async_req) begin
          state_d = StIdle;
        end else if ((cnt_q == '0) && pipeline_idle) begin
          state_d = StEnter;
          cause_d = async_cause;
          fault_d = resume_pc;
        end
      end

      StEnter: begin
        state_d = StHold;
        cnt_d   = HoldLoad;
      end

      StHold: begin
        // HOLD lasts HOLD_CYCLES cycles: leave when this decrement reaches zero.
        cnt_d = (cnt_q == '0) ? '0 : cnt_q - CntW'(1);
        if (cnt_q <= CntW'(1)) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_comb begin
    vec_off = 6'h00;
    case (cause_q)
      CauseIllegal: vec_off = 6'h04;
      CauseIrq:     vec_off = 6'h0C;
      CauseIfetch:  vec_off = 6'h10;
      CauseData:    vec_off = 6'h14;
`ifdef OLDLAND_EXC_NMI_EN
      CauseNmi:     vec_off = 6'h18;
`endif
      default:      vec_off = 6'h00;
    endcase
  end

  always_comb begin
    stall_fetch            = (state_q == StDrain);
    busy                   = (state_q != StIdle);
    exception_start        = in_enter & cause_is_sync;
    irq_start              = in_enter & ~cause_is_sync;
    exception_disable_irqs = in_enter;
    branch_req             = in_enter;
    branch_target          = in_enter ? ({vector_base, 6'b0} + {26'b0, vec_off}) : 32'h0;
    irq_fault_address      = fault_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cause_q <= CauseIllegal;
      cnt_q   <= '0;
      pend_q  <= 3'b000;
      fault_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_oldland_exc_sequencer.sv
// Bench for oldland_exc_sequencer: a directed vector table, hand-built corner
// sequences and randomized traffic checked against a behavioural model.
module tb_oldland_exc_sequencer;

  localparam int DRAIN_MIN   = 2;
  localparam int HOLD_CYCLES = 2;
  localparam logic [31:0] OFFS [4] = '{32'h04, 32'h10, 32'h14, 32'h0C};

  logic        clk = 1'b0;
  logic        rst;
  logic [25:0] vector_base;
  logic        irqs_enabled, irq_req, illegal_instr, ifetch_abort, data_abort;
  logic        pipeline_idle;
  logic [31:0] resume_pc;
  logic        stall_fetch, flush, exception_start, irq_start, exception_disable_irqs;
  logic [31:0] irq_fault_address;
  logic        branch_req;
  logic [31:0] branch_target;
  logic        busy;
`ifdef OLDLAND_EXC_NMI_EN
  logic        nmi_req = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  oldland_exc_sequencer #(
    .DRAIN_MIN  (DRAIN_MIN),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .vector_base           (vector_base),
    .irqs_enabled          (irqs_enabled),
    .irq_req               (irq_req),
    .illegal_instr         (illegal_instr),
    .ifetch_abort          (ifetch_abort),
    .data_abort            (data_abort),
    .pipeline_idle         (pipeline_idle),
    .resume_pc             (resume_pc),
`ifdef OLDLAND_EXC_NMI_EN
    .nmi_req               (nmi_req),
`endif
    .stall_fetch           (stall_fetch),
    .flush                 (flush),
    .exception_start       (exception_start),
    .irq_start             (irq_start),
    .exception_disable_irqs(exception_disable_irqs),
    .irq_fault_address     (irq_fault_address),
    .branch_req            (branch_req),
    .branch_target         (branch_target),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  // Flags order: {flush, stall, exc_start, irq_start, branch_req, disable_irqs, busy}
  localparam logic [6:0] FZ = 7'b0000000;
  localparam logic [6:0] FL = 7'b1000000;
  localparam logic [6:0] DR = 7'b0100001;
  localparam logic [6:0] EX = 7'b0010111;
  localparam logic [6:0] IQ = 7'b0001111;
  localparam logic [6:0] HD = 7'b0000001;

  typedef struct {
    logic        rst, ill, ifa, da, irq, en, pidle;
    logic [6:0]  flags;
    logic [31:0] tgt;
    logic [31:0] fault;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: phase 0 idle, 1 draining, 2 entering, 3 refractory.
  bit          m_pend [3];   // 0 illegal, 1 ifetch, 2 data
  int          m_phase, m_drain, m_hold, m_cause;
  logic [31:0] m_fault;

  function automatic logic [70:0] dut_obs();
    return {flush, stall_fetch, exception_start, irq_start, branch_req,
            exception_disable_irqs, busy, branch_target, irq_fault_address};
  endfunction

  function automatic void chk(string name, logic [70:0] act, logic [70:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got flags=%b tgt=%h fault=%h, want flags=%b tgt=%h fault=%h",
               name, $time, act[70:64], act[63:32], act[31:0],
               exp[70:64], exp[63:32], exp[31:0]);
    end
  endfunction

  function automatic int top_pend();
    for (int i = 2; i >= 0; i--) if (m_pend[i]) return i;
    return -1;
  endfunction

  function automatic logic [70:0] model_obs();
    logic [6:0]  f;
    logic [31:0] t;
    bit ent;
    ent = (m_phase == 2);
    f = {(m_phase <= 1) && (top_pend() >= 0), m_phase == 1, ent && (m_cause < 3),
         ent && (m_cause == 3), ent, ent, m_phase != 0};
    t = ent ? ({vector_base, 6'b0} + OFFS[m_cause]) : 32'h0;
    return {f, t, m_fault};
  endfunction

  function automatic void model_next();
    int  top;
    bit  qual;
    top  = top_pend();
    qual = irq_req && irqs_enabled;
    if (rst) begin
      m_pend = '{0, 0, 0};
      m_phase = 0; m_drain = 0; m_hold = 0; m_cause = 0; m_fault = 32'h0;
      return;
    end
    case (m_phase)
      0: if (top >= 0) begin
           m_phase = 2; m_cause = top;
         end else if (qual) begin
           m_phase = 1; m_drain = DRAIN_MIN;
         end
      1: begin
           if (top >= 0) begin
             m_phase = 2; m_cause = top;
           end else if (!qual) begin
             m_phase = 0;
           end else if (m_drain == 0 && pipeline_idle) begin
             m_phase = 2; m_cause = 3; m_fault = resume_pc;
           end
           if (m_drain > 0) m_drain--;
         end
      2: begin
           if (m_cause < 3) m_pend[m_cause] = 0;
           m_phase = 3; m_hold = HOLD_CYCLES;
         end
      default: begin
           m_hold--;
           if (m_hold == 0) m_phase = 0;
         end
    endcase
    if (illegal_instr) m_pend[0] = 1;
    if (ifetch_abort)  m_pend[1] = 1;
    if (data_abort)    m_pend[2] = 1;
  endfunction

  task automatic advance();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic mcycle(string name);
    @(negedge clk);
    chk(name, dut_obs(), model_obs());
    advance();
  endtask

  task automatic drive(logic r, logic il, logic fa, logic d, logic ir, logic e, logic p);
    rst = r; illegal_instr = il; ifetch_abort = fa; data_abort = d;
    irq_req = ir; irqs_enabled = e; pipeline_idle = p;
  endtask

  function automatic void add(logic r, logic il, logic fa, logic d, logic ir, logic e,
                              logic p, logic [6:0] f, logic [31:0] t, logic [31:0] fa_exp);
    vec_t v;
    v.rst = r; v.ill = il; v.ifa = fa; v.da = d; v.irq = ir; v.en = e; v.pidle = p;
    v.flags = f; v.tgt = t; v.fault = fa_exp;
    tbl.push_back(v);
  endfunction

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    vector_base = 26'h1;
    resume_pc   = 32'h1000;
    repeat (2) begin
      @(negedge clk);
      advance();
    end
    @(negedge clk);
    chk("reset_state", dut_obs(), 71'h0);
    advance();
    drive(0, 0, 0, 0, 0, 1, 0);

    //  rst ill ifa da irq en pidle flags tgt          fault
    add(0, 1, 0, 0, 0, 1, 0, FZ, 32'h0,  32'h0);     // illegal pulse
    add(0, 0, 0, 0, 0, 1, 0, FL, 32'h0,  32'h0);
    add(0, 0, 0, 0, 0, 1, 0, EX, 32'h44, 32'h0);
    add(0, 0, 0, 0, 0, 1, 0, HD, 32'h0,  32'h0);
    add(0, 0, 0, 0, 0, 1, 0, HD, 32'h0,  32'h0);
    add(0, 0, 0, 0, 0, 1, 0, FZ, 32'h0,  32'h0);
    add(0, 0, 0, 0, 1, 1, 0, FZ, 32'h0,  32'h0);     // irq qualifies
    add(0, 0, 0, 0, 1, 1, 0, DR, 32'h0,  32'h0);
    add(0, 0, 0, 0, 1, 1, 0, DR, 32'h0,  32'h0);
    add(0, 0, 0, 0, 1, 1, 1, DR, 32'h0,  32'h0);
    add(0, 0, 0, 0, 0, 1, 1, IQ, 32'h4C, 32'h1000);
    add(0, 0, 0, 0, 0, 1, 0, HD, 32'h0,  32'h1000);
    add(0, 0, 0, 0, 0, 1, 0, HD, 32'h0,  32'h1000);
    add(0, 0, 0, 0, 0, 1, 0, FZ, 32'h0,  32'h1000);
    add(0, 0, 0, 0, 1, 1, 0, FZ, 32'h0,  32'h1000);  // irq abandoned in drain
    add(0, 0, 0, 0, 1, 1, 0, DR, 32'h0,  32'h1000);
    add(0, 0, 0, 0, 0, 1, 0, DR, 32'h0,  32'h1000);
    add(0, 0, 0, 0, 0, 1, 0, FZ, 32'h0,  32'h1000);
    add(0, 0, 0, 0, 0, 1, 0, FZ, 32'h0,  32'h1000);
    add(0, 1, 0, 1, 0, 1, 0, FZ, 32'h0,  32'h1000);  // data abort + illegal
    add(0, 0, 0, 0, 0, 1, 0, FL, 32'h0,  32'h1000);
    add(0, 0, 0, 0, 0, 1, 0, EX, 32'h54, 32'h1000);
    add(0, 0, 0, 0, 0, 1, 0, HD, 32'h0,  32'h1000);
    add(0, 0, 0, 0, 0, 1, 0, HD, 32'h0,  32'h1000);
    add(0, 0, 0, 0, 0, 1, 0, FL, 32'h0,  32'h1000);
    add(0, 0, 0, 0, 0, 1, 0, EX, 32'h44, 32'h1000);
    add(0, 0, 0, 0, 0, 1, 0, HD, 32'h0,  32'h1000);
    add(0, 0, 0, 0, 0, 1, 0, HD, 32'h0,  32'h1000);
    add(0, 0, 0, 0, 0, 1, 0, FZ, 32'h0,  32'h1000);
    add(0, 0, 0, 0, 1, 1, 0, FZ, 32'h0,  32'h1000);  // reset mid-drain
    add(1, 0, 0, 0, 0, 1, 0, DR, 32'h0,  32'h1000);
    add(0, 0, 0, 0, 0, 1, 0, FZ, 32'h0,  32'h0);
    add(0, 0, 0, 0, 0, 1, 0, FZ, 32'h0,  32'h0);
    add(0, 0, 0, 0, 1, 0, 0, FZ, 32'h0,  32'h0);     // irq masked
    add(0, 0, 0, 0, 1, 0, 0, FZ, 32'h0,  32'h0);
    add(0, 0, 0, 0, 0, 1, 0, FZ, 32'h0,  32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].ill, tbl[i].ifa, tbl[i].da, tbl[i].irq, tbl[i].en,
            tbl[i].pidle);
      @(negedge clk);
      chk($sformatf("vec%0d", i), dut_obs(), {tbl[i].flags, tbl[i].tgt, tbl[i].fault});
      advance();
    end

    // Sync fault arriving during DRAIN wins over the pending IRQ.
    vector_base = 26'h2A5; resume_pc = 32'h2222;
    drive(0, 0, 0, 0, 1, 1, 0);
    mcycle("drain_sync_a");
    mcycle("drain_sync_b");
    drive(0, 0, 1, 0, 1, 1, 0);
    mcycle("drain_sync_c");
    drive(0, 0, 0, 0, 0, 1, 0);
    repeat (6) mcycle("drain_sync_d");

    // Fault arriving in HOLD stays pending and is taken afterwards.
    drive(0, 1, 0, 0, 0, 1, 0);
    mcycle("nest_a");
    drive(0, 0, 0, 0, 0, 1, 0);
    mcycle("nest_b");
    drive(0, 0, 0, 1, 0, 1, 0);
    mcycle("nest_c");
    drive(0, 0, 0, 0, 0, 1, 0);
    repeat (8) mcycle("nest_d");

    // Pipeline never idles: DRAIN holds with a saturated counter, then enters.
    drive(0, 0, 0, 0, 1, 1, 0);
    repeat (8) mcycle("long_drain");
    pipeline_idle = 1'b1;
    repeat (6) mcycle("long_drain_exit");

    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 299) == 0);
      illegal_instr = ($urandom_range(0, 19) == 0);
      ifetch_abort  = ($urandom_range(0, 29) == 0);
      data_abort    = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) == 0)  irq_req = ~irq_req;
      if ($urandom_range(0, 19) == 0) irqs_enabled = ~irqs_enabled;
      pipeline_idle = ($urandom_range(0, 2) != 0);
      resume_pc     = $urandom;
      if ($urandom_range(0, 63) == 0) vector_base = 26'($urandom);
      mcycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
